hc_sr04_scanner: RTL

//  Multi-channel HC-SR04 ultrasonic ranger with integrated us/cm timebase.

---
 rtl/hc_sr04_scanner.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hc_sr04_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hc_sr04_scanner                                               |
// | Purpose  : Round-robin multi-channel HC-SR04 ultrasonic ranger with a    |
// |            built-in microsecond/centimetre timebase. One sensor is       |
// |            pinged at a time. Each echo pulse width is converted to cm,   |
// |            with timeout, saturation and a one-cycle result strobe.       |
// | Ports    : clk        - system clock, rising edge                         |
// |            rst        - synchronous reset, active-high                    |
// |            en_i       - 1 = keep scanning, 0 = park after current ping    |
// |            echo_i     - asynchronous echo pins, one per sensor            |
// |            trigger_o  - trigger pins, at most one bit high               |
// |            range_o    - last result per channel (cm), ch k at k*RW       |
// |            timeout_o  - 1 = last ping of that channel timed out          |
// |            valid_o    - one-cycle strobe, a new result was written       |
// |            valid_ch_o - channel of the result while valid_o=1            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hc_sr04_scanner #(
  parameter int CLK_HZ      = 50000000,
  parameter int CHANNELS    = 2,
  parameter int RANGE_WIDTH = 16,
  parameter int TRIG_US     = 10,
  parameter int US_PER_CM   = 58,
  parameter int TIMEOUT_US  = 30000,
  parameter int GAP_US      = 60000,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_i,
  input  logic [CHANNELS-1:0]             echo_i,
  output logic [CHANNELS-1:0]             trigger_o,
  output logic [CHANNELS*RANGE_WIDTH-1:0] range_o,
  output logic [CHANNELS-1:0]             timeout_o,
  output logic                            valid_o,
  output logic [CH_W-1:0]                 valid_ch_o
);

  localparam int c_div    = CLK_HZ / 1000000;
  localparam int c_pw     = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_us_max = (TIMEOUT_US > GAP_US) ?
                            ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US) :
                            ((GAP_US > TRIG_US) ? GAP_US : TRIG_US);
  localparam int c_uw     = $clog2(c_us_max + 1);
  localparam int c_sw     = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [c_pw-1:0]        c_presc_last = c_pw'(c_div - 1);
  localparam logic [c_uw-1:0]        c_trig_last  = c_uw'(TRIG_US - 1);
  localparam logic [c_uw-1:0]        c_tout_last  = c_uw'(TIMEOUT_US - 1);
  localparam logic [c_uw-1:0]        c_gap_last   = c_uw'(GAP_US - 1);
  localparam logic [c_sw-1:0]        c_sub_last   = c_sw'(US_PER_CM - 1);
  localparam logic [CH_W-1:0]        c_ch_last    = CH_W'(CHANNELS - 1);
  localparam logic [RANGE_WIDTH-1:0] c_rng_max    = '1;

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_trig = 3'd1;
  localparam logic [2:0] c_st_wait = 3'd2;
  localparam logic [2:0] c_st_meas = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;
  localparam logic [2:0] c_st_tout = 3'd5;
  localparam logic [2:0] c_st_gap  = 3'd6;

  logic [2:0]                      state_q, state_d;
  logic [CH_W-1:0]                 ch_q, ch_d;
  logic [c_pw-1:0]                 presc_q, presc_d;
  logic [c_uw-1:0]                 us_q, us_d;
  logic [c_uw-1:0]                 tot_q, tot_d;
  logic [c_sw-1:0]                 sub_q, sub_d;
  logic [RANGE_WIDTH-1:0]          cm_q, cm_d;
  logic [CHANNELS-1:0]             sync1_q, echo_s_q, echo_p_q;
  logic [CHANNELS-1:0]             trigger_q, trigger_d;
  logic [CHANNELS*RANGE_WIDTH-1:0] range_q;
  logic [CHANNELS-1:0]             timeout_q;
  logic                            valid_q;
  logic [CH_W-1:0]                 valid_ch_q;

  logic sel_s, sel_p, rise, fall, us_tick, xfer, result;

  // Only the channel currently being pinged is looked at.
  always_comb begin
    sel_s = 1'b0;
    sel_p = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_s = echo_s_q[k];
        sel_p = echo_p_q[k];
      end
    end
  end

  assign rise    = sel_s & ~sel_p;
  assign fall    = ~sel_s & sel_p;
  assign us_tick = (presc_q == c_presc_last);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      c_st_idle: if (en_i) state_d = c_st_trig;
      c_st_trig: if (us_tick && us_q == c_trig_last) state_d = c_st_wait;
      // tot_q spans WAIT_RISE and MEASURE so the timeout covers the whole echo.
      c_st_wait: begin
        if (rise)                                  state_d = c_st_meas;
        else if (us_tick && tot_q == c_tout_last)  state_d = c_st_tout;
      end
      c_st_meas: begin
        if (fall)                                  state_d = c_st_done;
        else if (us_tick && tot_q == c_tout_last)  state_d = c_st_tout;
      end
      c_st_done,
      c_st_tout: state_d = c_st_gap;
      c_st_gap: begin
        if (us_tick && us_q == c_gap_last) begin
          state_d = c_st_idle;
          ch_d    = (ch_q == c_ch_last) ? '0 : ch_q + 1'b1;
        end
      end
      default:   state_d = c_st_idle;
    endcase
  end

  // Timebase restarts on every transition so each timed state is N*DIV cycles.
  assign xfer = (state_d != state_q);

  always_comb begin
    presc_d = (xfer || us_tick) ? '0 : presc_q + 1'b1;
    us_d    = xfer ? '0 : (us_tick ? us_q + 1'b1 : us_q);
    tot_d   = '0;
    if (state_q == c_st_wait || state_q == c_st_meas)
      tot_d = us_tick ? tot_q + 1'b1 : tot_q;

    sub_d = sub_q;
    cm_d  = cm_q;
    // The tick landing on the falling-edge cycle still counts toward cm.
    if (state_q == c_st_meas && us_tick) begin
      if (sub_q == c_sub_last) begin
        sub_d = '0;
        cm_d  = (cm_q == c_rng_max) ? cm_q : cm_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
    if (xfer)                sub_d = '0;
    if (state_q == c_st_wait) cm_d = '0;

    for (int k = 0; k < CHANNELS; k++)
      trigger_d[k] = (state_d == c_st_trig) && (ch_d == CH_W'(k));
  end

  assign result = (state_d == c_st_done) || (state_d == c_st_tout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      ch_q       <= '0;
      presc_q    <= '0;
      us_q       <= '0;
      tot_q      <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      sync1_q    <= '0;
      echo_s_q   <= '0;
      echo_p_q   <= '0;
      trigger_q  <= '0;
      range_q    <= '0;
      timeout_q  <= '0;
      valid_q    <= 1'b0;
      valid_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      presc_q   <= presc_d;
      us_q      <= us_d;
      tot_q     <= tot_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      sync1_q   <= echo_i;
      echo_s_q  <= sync1_q;
      echo_p_q  <= echo_s_q;
      trigger_q <= trigger_d;
      valid_q   <= result;
      if (result) begin
        valid_ch_q <= ch_q;
        for (int k = 0; k < CHANNELS; k++) begin
          if (ch_q == CH_W'(k)) begin
            range_q[k*RANGE_WIDTH +: RANGE_WIDTH] <= (state_d == c_st_tout) ? c_rng_max : cm_d;
            timeout_q[k] <= (state_d == c_st_tout);
          end
        end
      end
    end
  end

  assign trigger_o  = trigger_q;
  assign range_o    = range_q;
  assign timeout_o  = timeout_q;
  assign valid_o    = valid_q;
  assign valid_ch_o = valid_ch_q;

endmodule
`default_nettype wire
